// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_control
// Description : Multi-cycle control FSM for the MIPS core datapath. Steps each
//               instruction through fetch, decode, execute, memory and
//               writeback states. Drives datapath mux selects and write
//               enables, stalls on the shared-memory ready handshake, and
//               counts retired instructions.
// Ports       : clock, reset     - system clock, synchronous active-high reset
//               opcode           - IR[31:26], decoded in DECODE
//               zero             - ALU zero flag, qualifies the branch PC load
//               mem_ready        - memory completes the current request
//               mem_req/mem_write/iord          - memory request controls
//               ir_write/reg_write/pc_en        - write enables
//               reg_dst/mem_to_reg/alu_src_a/alu_src_b/alu_op/pc_src - selects
//               illegal_op       - one-cycle pulse on an undecodable opcode
//               state            - current state encoding (debug)
//               retired          - retired-instruction count, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_J     = 6'h02;

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_dec_state;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic             w_mem_req;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_reg_write;
    logic             w_pc_en;
    logic             w_illegal;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // While reset is held the outputs are decoded as if in FETCH, so a reset
    // arriving mid-instruction presents a quiet datapath in the same cycle.
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    C_OP_RTYPE:      w_next_state = S_EXEC;
                    C_OP_LW,
                    C_OP_SW:         w_next_state = S_MEMADR;
                    C_OP_BEQ:        w_next_state = S_BRANCH;
                    C_OP_ADDI:       w_next_state = S_ADDIEX;
                    C_OP_J:          w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (opcode == C_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_next_state = mem_ready ? S_FETCH : S_MEMWR;
                w_retire     = mem_ready;
            end
            S_EXEC:   w_next_state = S_ALUWB;
            S_ALUWB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            S_JUMP: begin
                w_next_state = S_FETCH;
                w_retire     = 1'b1;
            end
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        iord        = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        w_pc_en     = 1'b0;

        case (w_dec_state)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle; only the ready cycle
                // commits it together with the IR load.
                w_mem_req  = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_en    = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                iord        = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                w_pc_en   = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                pc_src  = 2'b10;
                w_pc_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_req    = w_mem_req   & ~reset;
    assign mem_write  = w_mem_write & ~reset;
    assign ir_write   = w_ir_write  & ~reset;
    assign reg_write  = w_reg_write & ~reset;
    assign pc_en      = w_pc_en     & ~reset;
    assign illegal_op = w_illegal   & ~reset;
    assign state      = r_state;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control FSM for the MIPS core datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps. Drives the datapath mux selects and write enables, stalls on a shared-memory ready handshake, and counts retired instructions. Sits inside `mips_core` between the instruction register and the datapath register/ALU/memory blocks.

## Interface
- `CNT_W`, default 32, width of the retired-instruction counter.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE.
- `zero`  in  1  ALU zero flag; used in BRANCH.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  access is a write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  destination: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct decode.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  PC load enable.
- `illegal_op`  out  1  one-cycle pulse on an undecodable opcode.
- `state`  out  4  current state encoding, for debug.
- `retired`  out  CNT_W  retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable; if entered, go to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - When mem_ready=1: ir_write=1 and pc_en=1, then go to DECODE.
  - Otherwise hold in FETCH with ir_write=pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x08 → ADDIEX
  - 0x02 → JUMP
  - any other → FETCH, with illegal_op=1 this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if opcode=0x23, else MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready go to MEMWB; otherwise hold.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. On mem_ready go to FETCH; otherwise hold.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- Any signal not listed for a state is 0.
- `retired` increments by 1 in the last cycle of each legal instruction: MEMWB, MEMWR with mem_ready, ALUWB, BRANCH (taken or not), ADDIWB, JUMP. It wraps modulo 2^CNT_W. Illegal opcodes are not counted.

## Timing
- All outputs are Moore-decoded from `state`, except:
  - pc_en in FETCH and BRANCH, and ir_write in FETCH, which are combinational on mem_ready and zero.
  - illegal_op, which is combinational in DECODE.
- Reset: on a clock edge with reset=1, state←FETCH and retired←0. While reset=1, mem_req, mem_write, ir_write, pc_en, reg_write and illegal_op are forced to 0. Other outputs take their FETCH values. Reset mid-instruction abandons the instruction, with no write issued in that cycle.
- Latency with zero memory wait (mem_ready held at 1), counted in cycles from FETCH entry to the next FETCH entry:
  - lw 5
  - R-type, sw, addi 4
  - beq, j 3
  - illegal 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_req stays high and all outputs stay stable during the wait.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → state=0, retired=0, no write enables high during reset; ir_write=pc_en=1 in the first cycle after release.
- lw (0x23), mem_ready=1 → state sequence 0,1,2,3,4,0; reg_write and mem_to_reg high only in state 4; retired=1.
- sw (0x2B) with mem_ready low for 2 cycles in MEMWR → state 5 held 3 cycles with mem_req=mem_write=1; retired increments only on the ready cycle.
- beq (0x04) run twice, zero=1 then zero=0 → pc_en=1 with pc_src=01 in state 8, then pc_en=0; retired increments both times; 3 cycles each.
- Opcode 0x3F → illegal_op pulses in DECODE, next state FETCH, retired unchanged. Then R-type followed by j (0x02) → states 0,1,6,7,0,1,11,0.
- Reset asserted in state 3 while mem_ready=0 → next state 0 and mem_req=0 during reset. Separately, preload retired to 2^CNT_W−1 (CNT_W=4) and retire one addi → retired=0.
